mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request capture to first data beat; legal range 1..15.
REQ-002 Parameter DEPTH, default 1024: backing store size in 32-bit words; power of two.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port mem_req  input  1  block-transfer request strobe from the cache controller.
REQ-006 Port mem_we  input  1  1 = writeback (cache to memory), 0 = refill (memory to cache); sampled with mem_req.
REQ-007 Port mem_addr  input  32  request byte address; bits [3:2] give the critical-word offset; bits [1:0] are ignored.
REQ-008 Port mem_wdata  input  32  writeback word for the beat offset currently shown on mem_beat.
REQ-009 Port mem_busy  output  1  high from request capture until after the last beat.
REQ-010 Port mem_valid  output  1  beat strobe: refill data valid, or writeback word captured.
REQ-011 Port mem_beat  output  2  word offset within the 4-word block for the current beat.
REQ-012 Port mem_rdata  output  32  refill data; valid only while mem_valid is high and the transfer is a refill.
REQ-013 Port mem_done  output  1  one-cycle pulse coincident with the fourth beat.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, BURST.
REQ-015 In IDLE, a rising edge with mem_req=1 SHALL capture mem_we, the block index mem_addr[31:4] mod (DEPTH/4), and start offset mem_addr[3:2]; state goes to WAIT and mem_busy asserts.
REQ-016 WAIT SHALL count LATENCY-1 further edges; the first BURST cycle SHALL occur exactly LATENCY cycles after the capture edge.
REQ-017 BURST SHALL last exactly 4 consecutive cycles with mem_valid=1; mem_beat sequence is start, start+1, start+2, start+3 (mod 4), i.e. wrap-around critical-word-first order.
REQ-018 Refill: mem_rdata SHALL equal store[block*4 + mem_beat] in each BURST cycle.
REQ-019 Writeback: at each rising edge ending a BURST cycle, mem_wdata SHALL be written to store[block*4 + mem_beat].
REQ-020 mem_done SHALL be high only in the fourth BURST cycle; the next edge returns the FSM to IDLE with mem_busy=0.
REQ-021 mem_req while the FSM is not in IDLE SHALL be ignored, with no queueing; a new request is accepted on the first edge after mem_busy falls.
REQ-022 mem_req held high continuously SHALL start back-to-back transfers, separated by exactly one IDLE cycle.
REQ-023 Address bits above the index range SHALL alias modulo DEPTH words, with no error indication.
REQ-024 Store initial content, at time zero only: word i = 32'h80000000 + 4*i.
REQ-025 A writeback followed by a refill of the same block SHALL return the written words.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, mem_busy=0, mem_valid=0, mem_done=0, mem_beat=0, mem_rdata=0, latency counter 0.
REQ-027 Reset SHALL NOT alter store contents.
REQ-028 Reset during a writeback SHALL abort the burst: words already written stay, remaining words are not written.
REQ-029 After rst falls, the first rising edge with mem_req=1 SHALL be accepted.

Verification
REQ-030 Refill, LATENCY=4, mem_addr=0x80000000 after reset: beats 4..7 cycles after capture; mem_beat 0,1,2,3; mem_rdata 0x80000000, 0x80000004, 0x80000008, 0x8000000C; mem_done on the fourth beat.
REQ-031 Critical word first, refill mem_addr=0x80000008: mem_beat order 2,3,0,1 with matching rdata 0x80000008, 0x8000000C, 0x80000000, 0x80000004.
REQ-032 Writeback to 0x80000000 with words 0x12345678, 0xAABBCCDD, 0xCAFE0001, 0xBEEF0002 (by beat), then refill of the same block: same four words returned in beat order.
REQ-033 mem_req pulsed during WAIT and during BURST: no effect on the ongoing transfer and no extra transfer; mem_req held high: second capture exactly one cycle after mem_done.
REQ-034 rst asserted after beat 1 of a writeback of all 0xFFFFFFFF to block 0: outputs go to 0 immediately; a later refill of block 0 returns 0xFFFFFFFF, 0xFFFFFFFF, 0x80000008, 0x8000000C.
REQ-035 Aliasing with DEPTH=1024: writeback to 0x80001000, then refill of 0x80000000, returns the written data.

Source files
------------

// File: rtl/mem_responder.sv
// Block-transfer memory responder: after a fixed latency, serves 4-word refills or
// accepts 4-word writebacks in critical-word-first order from a word-addressed store.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_busy,
    output logic        mem_valid,
    output logic [1:0]  mem_beat,
    output logic [31:0] mem_rdata,
    output logic        mem_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = AW - 2;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2} state_t;

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic [1:0]      nbeat_r, nbeat_s;
    logic            we_r, we_s;
    logic [BW-1:0]   blk_r, blk_s;
    logic [1:0]      start_r, start_s;
    logic            busy_r, busy_s, valid_r, valid_s, done_r, done_s;
    logic [1:0]      beat_r, beat_s;
    logic [31:0]     rdata_r, rdata_s;
    logic [1:0]      next_off_s;
    logic [AW-1:0]   rd_idx_s, wr_idx_s;
    logic [31:0]     rd_word_s;
    logic            unused_addr_s;

    // Words never written read back as their power-up pattern, so no load loop is needed.
    logic [31:0]     store [DEPTH];
    logic [DEPTH-1:0] written = '0;

    function automatic logic [31:0] init_word(input logic [AW-1:0] idx);
        return 32'h8000_0000 + {{(30-AW){1'b0}}, idx, 2'b00};
    endfunction

    assign unused_addr_s = ^{mem_addr[31:AW+2], mem_addr[1:0]};
    assign next_off_s    = (state_r == WAIT) ? start_r : (beat_r + 2'd1);
    assign rd_idx_s      = {blk_r, next_off_s};
    assign wr_idx_s      = {blk_r, beat_r};
    assign rd_word_s     = written[rd_idx_s] ? store[rd_idx_s] : init_word(rd_idx_s);

    // Next-state and next-output decode for the IDLE/WAIT/BURST sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        nbeat_s = nbeat_r;
        we_s    = we_r;
        blk_s   = blk_r;
        start_s = start_r;
        busy_s  = busy_r;
        valid_s = 1'b0;
        done_s  = 1'b0;
        beat_s  = 2'd0;
        rdata_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (mem_req) begin
                    state_s = WAIT;
                    cnt_s   = 4'd0;
                    we_s    = mem_we;
                    blk_s   = mem_addr[AW+1:4];
                    start_s = mem_addr[3:2];
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r == 4'(LATENCY - 1)) begin
                    state_s = BURST;
                    nbeat_s = 2'd0;
                    valid_s = 1'b1;
                    beat_s  = next_off_s;
                    rdata_s = we_r ? 32'd0 : rd_word_s;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            BURST: begin
                if (nbeat_r == 2'd3) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end else begin
                    nbeat_s = nbeat_r + 2'd1;
                    valid_s = 1'b1;
                    beat_s  = next_off_s;
                    rdata_s = we_r ? 32'd0 : rd_word_s;
                    done_s  = (nbeat_r == 2'd2);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset clears everything except the store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            nbeat_r <= 2'd0;
            we_r    <= 1'b0;
            blk_r   <= '0;
            start_r <= 2'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            beat_r  <= 2'd0;
            rdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            nbeat_r <= nbeat_s;
            we_r    <= we_s;
            blk_r   <= blk_s;
            start_r <= start_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
            done_r  <= done_s;
            beat_r  <= beat_s;
            rdata_r <= rdata_s;
        end
    end

    // Writeback beat commit; reset forces IDLE so an aborted burst writes nothing further.
    always_ff @(posedge clk) begin
        if (state_r == BURST && we_r) begin
            store[wr_idx_s]   <= mem_wdata;
            written[wr_idx_s] <= 1'b1;
        end
    end

    assign mem_busy  = busy_r;
    assign mem_valid = valid_r;
    assign mem_beat  = beat_r;
    assign mem_rdata = rdata_r;
    assign mem_done  = done_r;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written corner
// sequences, and random transfers checked against a word-array reference model.
module tb_mem_responder;
    localparam int L = 4;
    localparam int D = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_busy, mem_valid, mem_done;
    logic [1:0]  mem_beat;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] model [D];
    logic [31:0] wbuf [4];
    logic [31:0] ebuf [4];

    typedef struct packed {
        logic            we;
        logic [31:0]     addr;
        logic [3:0][31:0] d;   // indexed by word offset: write data or expected read data
    } vec_t;

    vec_t tbl [6];

    mem_responder #(.LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
        .mem_valid(mem_valid), .mem_beat(mem_beat), .mem_rdata(mem_rdata),
        .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_busy"},  32'(mem_busy),  32'd0);
        check({nm, "_valid"}, 32'(mem_valid), 32'd0);
        check({nm, "_done"},  32'(mem_done),  32'd0);
        check({nm, "_beat"},  32'(mem_beat),  32'd0);
        check({nm, "_rdata"}, mem_rdata,      32'd0);
    endtask

    function automatic int blk_of(input logic [31:0] addr);
        return int'((addr >> 4) % (D / 4));
    endfunction

    task automatic load_exp(input logic [31:0] addr);
        for (int j = 0; j < 4; j++) ebuf[j] = model[blk_of(addr) * 4 + j];
    endtask

    // One complete transfer from an IDLE cycle; abort_at >= 0 raises rst in that beat.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input bit hold,
                           input bit poke, input int abort_at);
        int blk, st, eb;
        blk = blk_of(addr);
        st  = int'(addr[3:2]);
        mem_req  = 1'b1;
        mem_we   = we;
        mem_addr = addr;
        step();
        mem_req = hold;
        check("cap_busy",  32'(mem_busy),  32'd1);
        check("cap_valid", 32'(mem_valid), 32'd0);
        for (int k = 1; k < L; k++) begin
            if (poke && k == 1) mem_req = 1'b1;
            step();
            mem_req = hold;
            check("wait_valid", 32'(mem_valid), 32'd0);
            check("wait_busy",  32'(mem_busy),  32'd1);
        end
        step();
        for (int b = 0; b < 4; b++) begin
            eb = (st + b) % 4;
            if (b == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero_outputs("abort");
                return;
            end
            mem_wdata = wbuf[eb];
            check("beat_valid", 32'(mem_valid), 32'd1);
            check("beat_busy",  32'(mem_busy),  32'd1);
            check("beat_order", 32'(mem_beat),  32'(eb));
            check("beat_done",  32'(mem_done),  (b == 3) ? 32'd1 : 32'd0);
            if (!we) check("rdata", mem_rdata, ebuf[eb]);
            if (poke && b == 1) mem_req = 1'b1;
            step();
            mem_req = hold;
            if (we) model[blk * 4 + eb] = wbuf[eb];
        end
        check("end_busy",  32'(mem_busy),  32'd0);
        check("end_valid", 32'(mem_valid), 32'd0);
    endtask

    // Writeback of all-ones to block 0 cut by reset after two beats, then refill of block 0.
    task automatic abort_seq();
        for (int j = 0; j < 4; j++) wbuf[j] = 32'hFFFF_FFFF;
        do_xfer(1'b1, 32'h8000_0000, 1'b0, 1'b0, 2);
        mem_req = 1'b0;
        step();
        check_zero_outputs("in_reset");
        rst = 1'b0;
        ebuf[0] = 32'hFFFF_FFFF;
        ebuf[1] = 32'hFFFF_FFFF;
        ebuf[2] = 32'h8000_0008;
        ebuf[3] = 32'h8000_000C;
        do_xfer(1'b0, 32'h8000_0000, 1'b0, 1'b0, -1);
    endtask

    initial begin
        logic hold_r;
        logic [31:0] a;
        logic w;

        for (int i = 0; i < D; i++) model[i] = 32'h8000_0000 + 32'(i) * 32'd4;

        tbl[0] = '{we: 1'b0, addr: 32'h8000_0000,
                   d: {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000}};
        tbl[1] = '{we: 1'b0, addr: 32'h8000_0008,
                   d: {32'h8000_000C, 32'h8000_0008, 32'h8000_0004, 32'h8000_0000}};
        tbl[2] = '{we: 1'b1, addr: 32'h8000_0000,
                   d: {32'hBEEF_0002, 32'hCAFE_0001, 32'hAABB_CCDD, 32'h1234_5678}};
        tbl[3] = '{we: 1'b0, addr: 32'h8000_0000,
                   d: {32'hBEEF_0002, 32'hCAFE_0001, 32'hAABB_CCDD, 32'h1234_5678}};
        tbl[4] = '{we: 1'b1, addr: 32'h8000_1000,
                   d: {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000}};
        tbl[5] = '{we: 1'b0, addr: 32'h8000_0000,
                   d: {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000}};

        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (2) step();
        check_zero_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (i == 2) abort_seq();
            for (int j = 0; j < 4; j++) begin
                wbuf[j] = tbl[i].d[j];
                ebuf[j] = tbl[i].d[j];
            end
            do_xfer(tbl[i].we, tbl[i].addr, 1'b0, 1'b0, -1);
        end

        // Requests during WAIT and BURST are dropped: no second transfer follows.
        load_exp(32'h8000_0044);
        do_xfer(1'b0, 32'h8000_0044, 1'b0, 1'b1, -1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("no_extra_busy", 32'(mem_busy), 32'd0);
        end

        // Held request: the second capture follows after exactly one idle cycle.
        load_exp(32'h8000_0020);
        do_xfer(1'b0, 32'h8000_0020, 1'b1, 1'b0, -1);
        load_exp(32'h8000_0034);
        do_xfer(1'b0, 32'h8000_0034, 1'b0, 1'b0, -1);

        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            a = $urandom;
            if (i % 3 == 0) a[31:6] = 26'($urandom_range(0, 3));
            hold_r = (i != 23) && ($urandom_range(0, 3) == 0);
            for (int j = 0; j < 4; j++) wbuf[j] = $urandom;
            load_exp(a);
            do_xfer(w, a, hold_r, 1'b0, -1);
        end
        mem_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
